// File: rtl/axi4_lite_master_cmd.sv
// AXI4-Lite master that turns a valid/ready command stream into single AXI4-Lite
// transactions and returns each result on a backpressured response stream.
// It has one transaction in flight at a time and a per-transaction watchdog.
module axi4_lite_master_cmd #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_write_o,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic [1:0]                rsp_resp_o,
    output logic                      rsp_timeout_o,

    output logic                      awvalid_o,
    input  logic                      awready_i,
    output logic [ADDRESS_WIDTH-1:0]  awaddr_o,

    output logic                      wvalid_o,
    input  logic                      wready_i,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    output logic [DATA_WIDTH/8-1:0]   wstrb_o,

    input  logic                      bvalid_i,
    output logic                      bready_o,
    input  logic [1:0]                bresp_i,

    output logic                      arvalid_o,
    input  logic                      arready_i,
    output logic [ADDRESS_WIDTH-1:0]  araddr_o,

    input  logic                      rvalid_i,
    output logic                      rready_o,
    input  logic [DATA_WIDTH-1:0]     rdata_i,
    input  logic [1:0]                rresp_i
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    // A zero limit disables the watchdog; the counter is kept one bit wide then.
    localparam int WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT =
        (TIMEOUT_CYCLES > 0) ? WDOG_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [WDOG_W-1:0] WDOG_MAX =
        (TIMEOUT_CYCLES > 0) ? WDOG_W'(TIMEOUT_CYCLES) : '0;
    localparam logic WDOG_ON = (TIMEOUT_CYCLES > 0);

    state_t                     state_q, state_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       awvalid_q, awvalid_d;
    logic                       wvalid_q, wvalid_d;
    logic                       bready_q, bready_d;
    logic                       arvalid_q, arvalid_d;
    logic                       rready_q, rready_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]    wstrb_q, wstrb_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                 rsp_resp_q, rsp_resp_d;
    logic                       rsp_timeout_q, rsp_timeout_d;
    logic [WDOG_W-1:0]          wdog_q, wdog_d;

    logic                       expired;
    logic                       abort;
    logic                       awPending;
    logic                       wPending;

    // Next-state, output and watchdog logic; every register holds unless a state says otherwise.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        wdog_d        = wdog_q;
        abort         = 1'b0;
        awPending     = awvalid_q && !awready_i;
        wPending      = wvalid_q && !wready_i;

        // Once the limit is reached the watchdog stays expired, so a late
        // request handshake cannot leave the response phase unguarded.
        expired = WDOG_ON && (wdog_q >= WDOG_LIMIT);

        if (state_q == WR_REQ || state_q == WR_RESP ||
            state_q == RD_REQ || state_q == RD_RESP) begin
            wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr_i;
                    wdata_d     = cmd_wdata_i;
                    wstrb_d     = cmd_wstrb_i;
                    wdog_d      = '0;
                    if (cmd_write_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end

            WR_REQ: begin
                if (awvalid_q && awready_i) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready_i) begin
                    wvalid_d = 1'b0;
                end
                if (!awPending && !wPending) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            WR_RESP: begin
                if (bvalid_i) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = bresp_i;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            RD_REQ: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            RD_RESP: begin
                if (rvalid_i) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b0;
                    rsp_rdata_d   = rdata_i;
                    rsp_resp_d    = rresp_i;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A hung slave: release the bus and report a SLVERR-coded timeout.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_write_d   = (state_q == WR_REQ) || (state_q == WR_RESP);
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            state_d       = RSP;
        end
    end

    // State and registered outputs; reset clears everything and drops any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            wdog_q        <= wdog_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_write_o   = rsp_write_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_resp_o    = rsp_resp_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign awvalid_o     = awvalid_q;
    assign awaddr_o      = addr_q;
    assign wvalid_o      = wvalid_q;
    assign wdata_o       = wdata_q;
    assign wstrb_o       = wstrb_q;
    assign bready_o      = bready_q;
    assign arvalid_o     = arvalid_q;
    assign araddr_o      = addr_q;
    assign rready_o      = rready_q;

endmodule
